memoria_sync: RTL and testbench
===============================

# memoria_sync

Synchronous, parametrised successor to the combinational byte memory used by the UART test datapath. It has a registered read with a one-cycle `ReadValid` strobe, and out-of-range address detection. A clear sequencer zero-fills the whole array after reset and on request. It sits between the UART receive/transmit control and any block that buffers bytes, keeping the existing `Address`/`MemWrite`/`ler`/`WriteData`/`ReadData` port vocabulary.

## Interface
- `DATA_W`, 8: data word width in bits.
- `ADDR_W`, 32: `Address` port width.
- `DEPTH`, 501: number of words; valid addresses are 0..DEPTH-1.
- `CNT_W`, `$clog2(DEPTH)`: sweep counter width (derived; do not override).

Ports:
- `Clock`  in  1  single clock; all state changes on the rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `Clear`  in  1  one-cycle request to zero-fill the array.
- `MemWrite`  in  1  write strobe.
- `ler`  in  1  read strobe.
- `Address`  in  ADDR_W  word address, unsigned.
- `WriteData`  in  DATA_W  write data.
- `ReadData`  out  DATA_W  registered read data.
- `ReadValid`  out  1  one-cycle pulse: `ReadData` updated this cycle.
- `AddrError`  out  1  one-cycle pulse: the last accepted access was out of range.
- `Busy`  out  1  sweep in progress; all accesses are ignored.

## Operation
- FSM states: SWEEP and READY.
- Reset forces SWEEP with the counter at 0. The memory array itself is not reset; SWEEP zero-fills it.
- SWEEP behaviour:
  - Each edge writes 0 to `mem[cnt]` and increments `cnt`.
  - At `cnt == DEPTH-1`, that edge writes the last word, clears `Busy` and enters READY.
  - `MemWrite`, `ler` and `Clear` are ignored; `ReadValid` and `AddrError` stay 0.
- READY behaviour, evaluated per edge in priority order:
  1. `Clear`=1: enter SWEEP with `cnt`=0 and `Busy`=1. Any simultaneous access is dropped.
  2. `MemWrite`=1:
     - If `Address` < DEPTH, write `mem[Address]` <= `WriteData`.
     - Otherwise leave the memory unchanged and pulse `AddrError`.
     - A simultaneous `ler` is ignored (write wins) and `ReadValid` stays 0.
  3. `ler`=1: `ReadValid` pulses.
     - If `Address` < DEPTH, `ReadData` <= `mem[Address]`.
     - Otherwise `ReadData` <= 0 and `AddrError` pulses.
  4. None of the above: `ReadValid`=0 and `AddrError`=0.
- `ReadData` holds its value between reads; it changes only on an accepted read.
- The range compare uses the full ADDR_W width. There is no wrap or truncation, so address DEPTH and above are errors.
- Back-to-back reads are allowed on every cycle, giving one result per cycle.

## Timing
- Output reset values, all asynchronous: `ReadData`=0, `ReadValid`=0, `AddrError`=0, `Busy`=1.
- Sweep length: DEPTH edges after `Reset` deasserts.
  - `Busy` falls at edge DEPTH.
  - The first access accepted is the one sampled at edge DEPTH+1.
- Clear latency: `Busy` rises at the edge that samples `Clear` and falls DEPTH edges later.
- Read latency is one cycle: with `ler` sampled at edge N, `ReadData` and `ReadValid` are valid after edge N, for exactly one cycle of `ReadValid`.
- Write-then-read:
  - A write at edge N followed by a read of the same address at edge N+1 returns the new data.
  - No same-edge read-during-write case exists, because write has priority.
- `AddrError` asserts in the same cycle as the corresponding `ReadValid`, or one cycle after a rejected write.
- Reset asserted mid-sweep or mid-access:
  - Outputs take their reset values immediately.
  - The sweep restarts from 0 after release.
  - Partially swept contents are don't-care until the new sweep completes.

## Test plan
- Reset release -> `Busy`=1 for exactly 501 cycles; then a read of address 0, 250 and 500 returns 0x00 with `ReadValid` pulsing 1 cycle after each `ler`.
- Write 0x5A to address 50, read address 50 on the next cycle -> `ReadData`=0x5A and `ReadValid`=1 one cycle later. Issue no further reads -> `ReadData` stays 0x5A.
- `MemWrite`=1 and `ler`=1 together at address 7 with `WriteData`=0x33 -> no `ReadValid`; a later read of 7 returns 0x33.
- Write 0xFF to address 501, then read address 0xFFFF_FFFF:
  - The write pulses `AddrError` with no memory change; a read of 500 is unchanged.
  - The read returns `ReadData`=0x00 with `ReadValid`=1 and `AddrError`=1.
- Fill addresses 0..500 with the pattern addr[7:0], then pulse `Clear`:
  - `Busy`=1 for 501 cycles, and writes attempted during that time are ignored.
  - Afterwards every address reads 0x00.
- Assert `Reset` at sweep count 200, release, and issue reads during `Busy` -> all reads ignored; `Busy` falls 501 cycles after release; outputs read 0 throughout reset.

Source files
------------

// File: rtl/memoria_sync_if.sv
// Access bus for memoria_sync: request strobes and address/data from the
// requester; registered read data, status pulses and Busy from the memory.
interface memoria_sync_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 32
);
  logic              Clear;
  logic              MemWrite;
  logic              ler;
  logic [ADDR_W-1:0] Address;
  logic [DATA_W-1:0] WriteData;
  logic [DATA_W-1:0] ReadData;
  logic              ReadValid;
  logic              AddrError;
  logic              Busy;

  modport master (
    output Clear, MemWrite, ler, Address, WriteData,
    input  ReadData, ReadValid, AddrError, Busy
  );

  modport slave (
    input  Clear, MemWrite, ler, Address, WriteData,
    output ReadData, ReadValid, AddrError, Busy
  );
endinterface

// File: rtl/memoria_sync.sv
// Byte memory with registered one-cycle read, range checking and a zero-fill sweep.
// No backpressure: requests are taken every cycle while READY and dropped while Busy.
module memoria_sync #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 501
) (
  input logic           Clock,
  input logic           Reset,
  memoria_sync_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [CNT_W-1:0]  LAST    = CNT_W'(DEPTH - 1);

  typedef enum logic {SWEEP, READY} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              in_range;
  logic [CNT_W-1:0]  idx;
  logic              mem_we;
  logic [CNT_W-1:0]  mem_addr;
  logic [DATA_W-1:0] mem_wdat;
  logic              rd_load;
  logic              rd_zero;
  logic              rd_vld_nxt;
  logic              err_nxt;

  // Full-width compare: any high address bit set is an error, never a wrap.
  assign in_range = bus.Address < DEPTH_A;
  assign idx      = bus.Address[CNT_W-1:0];
  assign bus.Busy = (state == SWEEP);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    mem_we     = 1'b0;
    mem_addr   = cnt;
    mem_wdat   = '0;
    rd_load    = 1'b0;
    rd_zero    = 1'b0;
    rd_vld_nxt = 1'b0;
    err_nxt    = 1'b0;
    case (state)
      SWEEP: begin
        mem_we = 1'b1;
        if (cnt == LAST) begin
          state_nxt = READY;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      READY: begin
        if (bus.Clear) begin
          state_nxt = SWEEP;
          cnt_nxt   = '0;
        end else if (bus.MemWrite) begin
          if (in_range) begin
            mem_we   = 1'b1;
            mem_addr = idx;
            mem_wdat = bus.WriteData;
          end else begin
            err_nxt = 1'b1;
          end
        end else if (bus.ler) begin
          rd_vld_nxt = 1'b1;
          rd_load    = 1'b1;
          rd_zero    = !in_range;
          err_nxt    = !in_range;
        end
      end
      default: state_nxt = SWEEP;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state         <= SWEEP;
      cnt           <= '0;
      bus.ReadData  <= '0;
      bus.ReadValid <= 1'b0;
      bus.AddrError <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      bus.ReadValid <= rd_vld_nxt;
      bus.AddrError <= err_nxt;
      if (rd_load) bus.ReadData <= rd_zero ? '0 : mem[idx];
    end
  end

  // Array is deliberately unreset; the sweep provides the defined contents.
  always_ff @(posedge Clock) begin
    if (mem_we) mem[mem_addr] <= mem_wdat;
  end
endmodule

// File: tb/tb_memoria_sync.sv
// Directed bench for memoria_sync: stimulus pushes expected read/error responses,
// an independent monitor pops and compares whenever the DUT pulses an output.
module tb_memoria_sync;
  localparam int DEPTH = 501;

  logic clk;
  logic rst;

  memoria_sync_if #(.DATA_W(8), .ADDR_W(32)) bus ();

  memoria_sync #(.DATA_W(8), .ADDR_W(32), .DEPTH(DEPTH)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic       vld;
    logic [7:0] dat;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input logic [31:0] addr, input logic [7:0] dat, input logic err);
    bus.ler     = 1'b1;
    bus.Address = addr;
    exp_q.push_back('{vld: 1'b1, dat: dat, err: err});
    @(posedge clk);
    #1;
    bus.ler = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [7:0] dat, input logic err);
    bus.MemWrite  = 1'b1;
    bus.Address   = addr;
    bus.WriteData = dat;
    if (err) exp_q.push_back('{vld: 1'b0, dat: 8'h00, err: 1'b1});
    @(posedge clk);
    #1;
    bus.MemWrite = 1'b0;
  endtask

  // mode 0: quiet, 1: junk writes, 2: junk reads while counting Busy edges
  task automatic wait_busy(input string name, input int mode);
    int n;
    n = 0;
    while (bus.Busy === 1'b1 && n < 2000) begin
      if (mode == 1) begin
        bus.MemWrite  = 1'b1;
        bus.Address   = n % DEPTH;
        bus.WriteData = 8'hAA;
      end else if (mode == 2) begin
        bus.ler     = 1'b1;
        bus.Address = n % DEPTH;
      end
      @(posedge clk);
      #1;
      n++;
    end
    bus.MemWrite = 1'b0;
    bus.ler      = 1'b0;
    chk(name, n, DEPTH);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_ReadData"}, {24'h0, bus.ReadData}, 32'h0);
    chk({name, "_ReadValid"}, {31'h0, bus.ReadValid}, 32'h0);
    chk({name, "_AddrError"}, {31'h0, bus.AddrError}, 32'h0);
    chk({name, "_Busy"}, {31'h0, bus.Busy}, 32'h1);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && (bus.ReadValid === 1'b1 || bus.AddrError === 1'b1)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output actual vld=%b dat=%02h err=%b required no output",
                 bus.ReadValid, bus.ReadData, bus.AddrError);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.ReadValid !== mon_e.vld || bus.AddrError !== mon_e.err ||
            (mon_e.vld && bus.ReadData !== mon_e.dat)) begin
          errors++;
          $display("FAIL response actual vld=%b dat=%02h err=%b required vld=%b dat=%02h err=%b",
                   bus.ReadValid, bus.ReadData, bus.AddrError, mon_e.vld, mon_e.dat, mon_e.err);
        end
      end
    end
  end

  initial begin
    rst           = 1'b1;
    bus.Clear     = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.ler       = 1'b0;
    bus.Address   = '0;
    bus.WriteData = '0;
    idle(2);
    chk_reset_outputs("reset");

    // Sweep after reset release, then zero reads at the edges of the array
    rst = 1'b0;
    wait_busy("busy_after_reset", 0);
    rd(32'd0, 8'h00, 1'b0);
    rd(32'd250, 8'h00, 1'b0);
    rd(32'd500, 8'h00, 1'b0);

    // Write then read next cycle; data must hold afterwards
    wr(32'd50, 8'h5A, 1'b0);
    rd(32'd50, 8'h5A, 1'b0);
    idle(3);
    chk("hold_ReadData", {24'h0, bus.ReadData}, 32'h5A);

    // Simultaneous write and read: write wins, no ReadValid
    bus.MemWrite  = 1'b1;
    bus.ler       = 1'b1;
    bus.Address   = 32'd7;
    bus.WriteData = 8'h33;
    idle(1);
    bus.MemWrite = 1'b0;
    bus.ler      = 1'b0;
    idle(1);
    rd(32'd7, 8'h33, 1'b0);

    // Out-of-range accesses
    wr(32'd501, 8'hFF, 1'b1);
    rd(32'd500, 8'h00, 1'b0);
    rd(32'd50, 8'h5A, 1'b0);
    rd(32'hFFFF_FFFF, 8'h00, 1'b1);
    idle(1);
    chk("oob_read_zeroes", {24'h0, bus.ReadData}, 32'h0);

    // Fill with addr[7:0], spot-check, then Clear with junk writes during the sweep
    for (int a = 0; a < DEPTH; a++) wr(a, a[7:0], 1'b0);
    rd(32'd300, 8'h2C, 1'b0);
    rd(32'd500, 8'hF4, 1'b0);
    rd(32'd255, 8'hFF, 1'b0);
    bus.Clear = 1'b1;
    idle(1);
    bus.Clear = 1'b0;
    wait_busy("busy_after_clear", 1);
    for (int a = 0; a < DEPTH; a++) rd(a, 8'h00, 1'b0);

    // Reset from READY with non-zero ReadData, then reset again mid-sweep at count 200
    wr(32'd10, 8'h77, 1'b0);
    rd(32'd10, 8'h77, 1'b0);
    idle(1);
    rst = 1'b1;
    #1;
    chk_reset_outputs("reset_ready");
    idle(1);
    rst = 1'b0;
    bus.ler     = 1'b1;
    bus.Address = 32'd10;
    idle(200);
    chk("busy_mid_sweep", {31'h0, bus.Busy}, 32'h1);
    rst = 1'b1;
    #1;
    chk_reset_outputs("reset_mid_sweep");
    idle(3);
    chk_reset_outputs("reset_held");
    rst = 1'b0;
    wait_busy("busy_after_rerelease", 2);
    rd(32'd10, 8'h00, 1'b0);
    rd(32'd499, 8'h00, 1'b0);

    idle(3);
    chk("pending_responses", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
